dispatcher: RTL and testbench

//  One-to-many steering unit; the fan-out counterpart of the round-robin merge arbiter.

---
 rtl/dispatcher.sv | 151 +++++++++++++++
 tb/tb_dispatcher.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// One-to-many steering unit: routes each upstream beat to a per-port 2-entry skid FIFO
// selected by dest_us; beats with an out-of-range dest are discarded and counted.
module dispatcher #(
  parameter int NUM_OUT = 4,
  parameter int WIDTH   = 10,
  parameter int DEST_W  = $clog2(NUM_OUT),
  parameter int DROP_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_us,
  input  logic [WIDTH-1:0]                data_us,
  input  logic [DEST_W-1:0]               dest_us,
  output logic                            stall_us,
  output logic [NUM_OUT-1:0]              valid_ds,
  output logic [NUM_OUT-1:0][WIDTH-1:0]   data_ds,
  input  logic [NUM_OUT-1:0]              stall_ds,
  output logic [DROP_W-1:0]               drop_cnt
);

  logic [NUM_OUT-1:0][1:0]            cnt_q, cnt_d;
  logic [NUM_OUT-1:0]                 head_q, head_d;
  logic [NUM_OUT-1:0]                 tail_q, tail_d;
  logic [NUM_OUT-1:0][1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DROP_W-1:0]                  drop_q, drop_d;
  logic                               dest_hit;

  // Port-side views and upstream stall; stall_us never looks at stall_ds.
  always_comb begin
    stall_us = 1'b0;
    dest_hit = 1'b0;
    valid_ds = '0;
    data_ds  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      dest_hit    = dest_hit | (dest_us == DEST_W'(i));
      stall_us    = stall_us | (valid_us & (dest_us == DEST_W'(i)) & (cnt_q[i] == 2'd2));
      valid_ds[i] = (cnt_q[i] != 2'd0);
      data_ds[i]  = mem_q[i][head_q[i]];
    end
  end

  assign drop_cnt = drop_q;

  // Next-state: per-port push/pop bookkeeping and the saturating drop counter.
  always_comb begin
    logic push, pop;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    drop_d = drop_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      push = valid_us & ~stall_us & (dest_us == DEST_W'(i));
      pop  = valid_ds[i] & ~stall_ds[i];
      if (push) begin
        mem_d[i][tail_q[i]] = data_us;
        tail_d[i]           = ~tail_q[i];
      end else begin
        tail_d[i] = tail_q[i];
      end
      if (pop) begin
        head_d[i] = ~head_q[i];
      end else begin
        head_d[i] = head_q[i];
      end
      case ({push, pop})
        2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    // Out-of-range dest is consumed silently; counter sticks at all-ones.
    if (valid_us && !dest_hit && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers; reset clears storage too so no stale payload is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      mem_q  <= '0;
      drop_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
      drop_q <= drop_d;
    end
  end

  dispatcher_chk #(
    .NUM_OUT (NUM_OUT),
    .WIDTH   (WIDTH),
    .DEST_W  (DEST_W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .valid_us (valid_us),
    .stall_us (stall_us),
    .data_us  (data_us),
    .dest_us  (dest_us),
    .cnt      (cnt_q)
  );

endmodule

// Simulation-only protocol checks: FIFO occupancy bound and upstream hold rule.
module dispatcher_chk #(
  parameter int NUM_OUT = 4,
  parameter int WIDTH   = 10,
  parameter int DEST_W  = 2
) (
  input logic                       clk,
  input logic                       rst,
  input logic                       valid_us,
  input logic                       stall_us,
  input logic [WIDTH-1:0]           data_us,
  input logic [DEST_W-1:0]          dest_us,
  input logic [NUM_OUT-1:0][1:0]    cnt
);

  logic              hold_q;
  logic [WIDTH-1:0]  data_q;
  logic [DEST_W-1:0] dest_q;

  // Remember a stalled beat and require the producer to present it again.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
    end else begin
      hold_q <= valid_us & stall_us;
      data_q <= data_us;
      dest_q <= dest_us;
      if (hold_q) begin
        assert (valid_us && (data_us == data_q) && (dest_us == dest_q));
      end
    end
    for (int i = 0; i < NUM_OUT; i++) begin
      assert (cnt[i] <= 2'd2);
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
// Directed and randomised self-checking bench for dispatcher (4-port build plus a
// 3-port build used for the illegal-dest / drop-counter boundary).
module tb_dispatcher;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_us;
  logic [9:0]       data_us;
  logic [1:0]       dest_us;
  logic             stall_us;
  logic [3:0]       valid_ds;
  logic [3:0][9:0]  data_ds;
  logic [3:0]       stall_ds;
  logic [7:0]       drop_cnt;

  logic             v3;
  logic [9:0]       d3;
  logic [1:0]       dest3;
  logic             stall3;
  logic [2:0]       vds3;
  logic [2:0][9:0]  dds3;
  logic [2:0]       sds3;
  logic [7:0]       drop3;

  int checks = 0;
  int errors = 0;

  logic [9:0] model_q [4][$];

  always #5 clk = ~clk;

  dispatcher #(.NUM_OUT(4), .WIDTH(10), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .valid_us(valid_us), .data_us(data_us), .dest_us(dest_us),
    .stall_us(stall_us), .valid_ds(valid_ds), .data_ds(data_ds), .stall_ds(stall_ds),
    .drop_cnt(drop_cnt)
  );

  dispatcher #(.NUM_OUT(3), .WIDTH(10), .DROP_W(8)) dut3 (
    .clk(clk), .rst(rst), .valid_us(v3), .data_us(d3), .dest_us(dest3),
    .stall_us(stall3), .valid_ds(vds3), .data_ds(dds3), .stall_ds(sds3),
    .drop_cnt(drop3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input logic [1:0] dst);
    valid_us = v;
    data_us  = d;
    dest_us  = dst;
  endtask

  initial begin
    logic       hold;
    logic       exp_stall;
    logic [9:0] a;

    rst = 1'b1; drive(1'b0, 10'h0, 2'd0); stall_ds = 4'b0000;
    v3 = 1'b0; d3 = 10'h0; dest3 = 2'd0; sds3 = 3'b000;
    tick(); tick();
    chk("rst_valid_ds", 32'(valid_ds), 32'h0);
    chk("rst_data_ds", 32'(data_ds), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_stall_us", 32'(stall_us), 32'h0);
    rst = 1'b0;

    // 1: one beat per port, visible one cycle after acceptance
    drive(1'b1, 10'h11, 2'd0); #1 chk("t1_stall0", 32'(stall_us), 32'h0); tick();
    drive(1'b1, 10'h12, 2'd1); #1
    chk("t1_v0", 32'(valid_ds), 32'h1); chk("t1_d0", 32'(data_ds[0]), 32'h11);
    chk("t1_stall1", 32'(stall_us), 32'h0); tick();
    drive(1'b1, 10'h13, 2'd2); #1
    chk("t1_v1", 32'(valid_ds), 32'h2); chk("t1_d1", 32'(data_ds[1]), 32'h12); tick();
    drive(1'b1, 10'h14, 2'd3); #1
    chk("t1_v2", 32'(valid_ds), 32'h4); chk("t1_d2", 32'(data_ds[2]), 32'h13); tick();
    drive(1'b0, 10'h0, 2'd0); #1
    chk("t1_v3", 32'(valid_ds), 32'h8); chk("t1_d3", 32'(data_ds[3]), 32'h14); tick();
    chk("t1_empty", 32'(valid_ds), 32'h0);

    // 2: port 2 stalled fills to 2, other port unaffected, drains in order
    stall_ds = 4'b0100;
    drive(1'b1, 10'hA0, 2'd2); #1 chk("t2_acc_a0", 32'(stall_us), 32'h0); tick();
    drive(1'b1, 10'hA1, 2'd2); #1 chk("t2_acc_a1", 32'(stall_us), 32'h0);
    chk("t2_head_a0", 32'(data_ds[2]), 32'hA0); tick();
    drive(1'b1, 10'hB1, 2'd1); #1 chk("t2_acc_b1", 32'(stall_us), 32'h0); tick();
    drive(1'b1, 10'hA2, 2'd2); #1
    chk("t2_stall_a2", 32'(stall_us), 32'h1); chk("t2_v", 32'(valid_ds), 32'h6);
    chk("t2_d1", 32'(data_ds[1]), 32'hB1); chk("t2_d2", 32'(data_ds[2]), 32'hA0); tick();
    stall_ds = 4'b0000; #1
    chk("t2_stall_hold", 32'(stall_us), 32'h1); chk("t2_v2only", 32'(valid_ds), 32'h4); tick();
    chk("t2_stall_rel", 32'(stall_us), 32'h0); chk("t2_d_a1", 32'(data_ds[2]), 32'hA1); tick();
    drive(1'b0, 10'h0, 2'd0); #1
    chk("t2_d_a2", 32'(data_ds[2]), 32'hA2); chk("t2_v_a2", 32'(valid_ds), 32'h4); tick();
    chk("t2_empty", 32'(valid_ds), 32'h0);

    // 3: push and pop together at cnt=1, no bubbles over 20 beats
    drive(1'b1, 10'h100, 2'd1); tick();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 10'(10'h100 + k), 2'd1); #1
      chk("t3_stall", 32'(stall_us), 32'h0);
      chk("t3_valid", 32'(valid_ds), 32'h2);
      chk("t3_data", 32'(data_ds[1]), 32'(10'h100 + k - 1));
      tick();
    end
    drive(1'b0, 10'h0, 2'd0); #1 chk("t3_last", 32'(data_ds[1]), 32'h114); tick();
    chk("t3_empty", 32'(valid_ds), 32'h0);

    // 5: reset with two full ports and a live upstream beat
    stall_ds = 4'b1001;
    drive(1'b1, 10'h50, 2'd0); tick();
    drive(1'b1, 10'h51, 2'd0); tick();
    drive(1'b1, 10'h53, 2'd3); tick();
    drive(1'b1, 10'h54, 2'd3); tick();
    drive(1'b0, 10'h0, 2'd0); #1
    chk("t5_full", 32'(valid_ds), 32'h9); chk("t5_stall_full", 32'(stall_us), 32'h0);
    rst = 1'b1; drive(1'b1, 10'h77, 2'd1); tick();
    rst = 1'b0; drive(1'b0, 10'h0, 2'd0); #1
    chk("t5_valid_ds", 32'(valid_ds), 32'h0); chk("t5_data_ds", 32'(data_ds), 32'h0);
    chk("t5_drop", 32'(drop_cnt), 32'h0); chk("t5_stall_us", 32'(stall_us), 32'h0); tick();
    chk("t5_no_accept", 32'(valid_ds), 32'h0);
    stall_ds = 4'b0000;

    // 4: 3-port build, legal beat then 300 illegal dest=3 beats
    v3 = 1'b1; d3 = 10'h2C; dest3 = 2'd2; #1 chk("t4_legal_stall", 32'(stall3), 32'h0); tick();
    v3 = 1'b1; d3 = 10'h3FF; dest3 = 2'd3; #1
    chk("t4_legal_v", 32'(vds3), 32'h4); chk("t4_legal_d", 32'(dds3[2]), 32'h2C);
    chk("t4_ill_stall", 32'(stall3), 32'h0); tick();
    chk("t4_no_valid", 32'(vds3), 32'h0); chk("t4_drop1", 32'(drop3), 32'h1);
    for (int k = 0; k < 253; k++) tick();
    chk("t4_drop254", 32'(drop3), 32'hFE);
    tick();
    chk("t4_drop255", 32'(drop3), 32'hFF);
    for (int k = 0; k < 45; k++) tick();
    chk("t4_drop_sat", 32'(drop3), 32'hFF); chk("t4_no_valid_end", 32'(vds3), 32'h0);
    v3 = 1'b0;

    // 6: random traffic against a per-port queue model
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        a = 10'($urandom_range(0, 1023));
        drive(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)));
      end
      stall_ds = 4'($urandom_range(0, 15));
      #1;
      exp_stall = valid_us && (model_q[dest_us].size() == 2);
      chk("t6_stall_us", 32'(stall_us), 32'(exp_stall));
      for (int i = 0; i < 4; i++) begin
        chk("t6_valid", 32'(valid_ds[i]), 32'(model_q[i].size() != 0));
        if (model_q[i].size() != 0) begin
          chk("t6_data", 32'(data_ds[i]), 32'(model_q[i][0]));
          if (!stall_ds[i]) void'(model_q[i].pop_front());
        end
      end
      if (valid_us && !exp_stall) model_q[dest_us].push_back(data_us);
      hold = exp_stall;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
